// File: rtl/i2s_pkg.sv
// Shared I2S definitions: slot geometry and the receiver state encoding.
package i2s_pkg;

    localparam int unsigned I2S_DATA_WIDTH = 24;
    localparam int unsigned I2S_SLOT_WIDTH = 32;

    typedef enum logic [1:0] {
        SYNC_WAIT = 2'd0,
        LEFT      = 2'd1,
        RIGHT     = 2'd2
    } rx_state_e;

endpackage

// File: rtl/i2s_receiver_if.sv
// Pin-side and bus-side signals of the I2S capture block.
// master: the bus logic / environment; slave: the receiver itself.
interface i2s_receiver_if
    import i2s_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = I2S_DATA_WIDTH
) ();

    logic                  enable;
    logic                  bclk;
    logic                  lrclk;
    logic                  sdata;
    logic [DATA_WIDTH-1:0] frame_out_l;
    logic [DATA_WIDTH-1:0] frame_out_r;
    logic                  frame_valid;
    logic                  read_frame;
    logic                  overflow;
    logic                  overflow_clr;
    logic                  slot_error;

    modport master (
        output enable, bclk, lrclk, sdata, read_frame, overflow_clr,
        input  frame_out_l, frame_out_r, frame_valid, overflow, slot_error
    );

    modport slave (
        input  enable, bclk, lrclk, sdata, read_frame, overflow_clr,
        output frame_out_l, frame_out_r, frame_valid, overflow, slot_error
    );

endinterface

// File: rtl/audio_frame_fifo.sv
// Synchronous show-ahead FIFO. data_o is a registered copy of the head entry and
// holds its last value while the FIFO is empty.
module audio_frame_fifo #(
    parameter int unsigned WIDTH = 48,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int unsigned AW   = $clog2(DEPTH);
    localparam int unsigned PtrW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_pop  = pop_i & ~empty_o;
    // A push into a full FIFO is still accepted when a pop frees a slot this cycle.
    assign do_push = push_i & (~full_o | do_pop);
    assign data_o  = head_q;

    // Next-state: storage write, pointer advance, and head refresh (with write bypass).
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q + PtrW'(do_push);
        rd_ptr_d = rd_ptr_q + PtrW'(do_pop);
        head_d   = head_q;
        if (do_push) begin
            mem_d[wr_ptr_q[AW-1:0]] = data_i;
        end
        if (wr_ptr_d != rd_ptr_d) begin
            head_d = mem_d[rd_ptr_d[AW-1:0]];
        end
    end

    // State registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            head_q   <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            head_q   <= head_d;
        end
    end

endmodule

// File: rtl/i2s_receiver.sv
// I2S capture: oversamples bclk/lrclk/sdata in the clk_soc domain, deserialises
// 24-bit left/right words and buffers complete stereo frames in a FIFO.
module i2s_receiver
    import i2s_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = I2S_DATA_WIDTH,
    parameter int unsigned SLOT_WIDTH = I2S_SLOT_WIDTH,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic          clk_soc,
    input  logic          reset,
    i2s_receiver_if.slave bus
);
    localparam int unsigned     CntW    = $clog2(SLOT_WIDTH + 1);
    localparam logic [CntW-1:0] CntData = CntW'(DATA_WIDTH);
    localparam logic [CntW-1:0] CntSat  = CntW'(SLOT_WIDTH);

    logic [2:0]            bclk_sync_q, bclk_sync_d;
    logic [1:0]            lrclk_sync_q, lrclk_sync_d;
    logic [1:0]            sdata_sync_q, sdata_sync_d;
    logic                  lr_prev_q, lr_prev_d;
    rx_state_e             state_q, state_d;
    logic [CntW-1:0]       bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0] shift_l_q, shift_l_d;
    logic [DATA_WIDTH-1:0] shift_r_q, shift_r_d;
    logic                  push_q, push_d;
    logic                  overflow_q, overflow_d;
    logic                  slot_error_q, slot_error_d;

    logic                    bclk_rise;
    logic                    lrclk_s;
    logic                    sdata_s;
    logic                    lr_change;
    logic                    short_slot;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic                    fifo_pop;
    logic                    overflow_set;
    logic [2*DATA_WIDTH-1:0] fifo_dout;

    assign bclk_rise = bclk_sync_q[1] & ~bclk_sync_q[2];
    assign lrclk_s   = lrclk_sync_q[1];
    assign sdata_s   = sdata_sync_q[1];
    // The rise carrying a word-select change holds the previous slot's last bit.
    assign lr_change = bclk_rise & (lrclk_s != lr_prev_q);

    // Synchroniser chains and word-select history.
    always_comb begin
        bclk_sync_d  = {bclk_sync_q[1:0], bus.bclk};
        lrclk_sync_d = {lrclk_sync_q[0], bus.lrclk};
        sdata_sync_d = {sdata_sync_q[0], bus.sdata};
        lr_prev_d    = bclk_rise ? lrclk_s : lr_prev_q;
    end

    // Capture FSM: slot tracking, bit shifting and frame push request.
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_l_d  = shift_l_q;
        shift_r_d  = shift_r_q;
        push_d     = 1'b0;
        short_slot = 1'b0;
        if (!bus.enable) begin
            state_d   = SYNC_WAIT;
            bit_cnt_d = '0;
        end else if (bclk_rise) begin
            unique case (state_q)
                SYNC_WAIT: begin
                    if (lr_change && !lrclk_s) begin
                        state_d   = LEFT;
                        bit_cnt_d = '0;
                    end
                end
                LEFT: begin
                    if (lr_change) begin
                        if (bit_cnt_q >= CntData) begin
                            state_d   = RIGHT;
                            bit_cnt_d = '0;
                        end else begin
                            short_slot = 1'b1;
                            state_d    = SYNC_WAIT;
                        end
                    end else begin
                        if (bit_cnt_q < CntData) begin
                            shift_l_d = {shift_l_q[DATA_WIDTH-2:0], sdata_s};
                        end
                        if (bit_cnt_q != CntSat) begin
                            bit_cnt_d = bit_cnt_q + 1'b1;
                        end
                    end
                end
                RIGHT: begin
                    if (lr_change) begin
                        if (bit_cnt_q >= CntData) begin
                            push_d    = 1'b1;
                            state_d   = LEFT;
                            bit_cnt_d = '0;
                        end else begin
                            short_slot = 1'b1;
                            state_d    = SYNC_WAIT;
                        end
                    end else begin
                        if (bit_cnt_q < CntData) begin
                            shift_r_d = {shift_r_q[DATA_WIDTH-2:0], sdata_s};
                        end
                        if (bit_cnt_q != CntSat) begin
                            bit_cnt_d = bit_cnt_q + 1'b1;
                        end
                    end
                end
                default: state_d = SYNC_WAIT;
            endcase
        end
    end

    assign fifo_pop     = bus.read_frame & ~fifo_empty;
    assign overflow_set = push_q & fifo_full & ~fifo_pop;

    // Sticky flags; a new event beats a simultaneous clear.
    always_comb begin
        overflow_d   = overflow_set | (overflow_q & ~bus.overflow_clr);
        slot_error_d = short_slot | (slot_error_q & ~bus.overflow_clr);
    end

    // State registers.
    always_ff @(posedge clk_soc or posedge reset) begin
        if (reset) begin
            bclk_sync_q  <= '0;
            lrclk_sync_q <= '0;
            sdata_sync_q <= '0;
            lr_prev_q    <= 1'b0;
            state_q      <= SYNC_WAIT;
            bit_cnt_q    <= '0;
            shift_l_q    <= '0;
            shift_r_q    <= '0;
            push_q       <= 1'b0;
            overflow_q   <= 1'b0;
            slot_error_q <= 1'b0;
        end else begin
            bclk_sync_q  <= bclk_sync_d;
            lrclk_sync_q <= lrclk_sync_d;
            sdata_sync_q <= sdata_sync_d;
            lr_prev_q    <= lr_prev_d;
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_l_q    <= shift_l_d;
            shift_r_q    <= shift_r_d;
            push_q       <= push_d;
            overflow_q   <= overflow_d;
            slot_error_q <= slot_error_d;
        end
    end

    audio_frame_fifo #(
        .WIDTH (2 * DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_soc),
        .rst_i   (reset),
        .push_i  (push_q),
        .data_i  ({shift_l_q, shift_r_q}),
        .pop_i   (fifo_pop),
        .data_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign bus.frame_out_l = fifo_dout[2*DATA_WIDTH-1:DATA_WIDTH];
    assign bus.frame_out_r = fifo_dout[DATA_WIDTH-1:0];
    assign bus.frame_valid = ~fifo_empty;
    assign bus.overflow    = overflow_q;
    assign bus.slot_error  = slot_error_q;

endmodule

// File: tb/tb_i2s_receiver.sv
// Directed bench for i2s_receiver: an I2S source model (bclk = clk_soc/26, 32-bit
// slots, data changing on bclk fall) driven from a table of stereo frames.
module tb_i2s_receiver;
    import i2s_pkg::*;

    localparam int unsigned DW   = I2S_DATA_WIDTH;
    localparam int          HALF = 13;

    typedef struct {
        logic [23:0] l;
        logic [23:0] r;
        bit          kept;  // expected to be readable from the FIFO afterwards
    } vec_t;

    logic clk_soc = 1'b0;
    logic reset;
    vec_t tbl [18];
    int   checks = 0;
    int   errors = 0;

    i2s_receiver_if #(.DATA_WIDTH(DW)) bus ();

    i2s_receiver #(
        .DATA_WIDTH (DW),
        .SLOT_WIDTH (32),
        .FIFO_DEPTH (4)
    ) dut (
        .clk_soc (clk_soc),
        .reset   (reset),
        .bus     (bus)
    );

    always #5 clk_soc = ~clk_soc;

    task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One bclk period; optionally pulse read_frame exactly on the resulting push cycle.
    task automatic send_bit(input bit lr, input bit d, input bit popx);
        bus.lrclk = lr;
        bus.sdata = d;
        repeat (HALF) @(negedge clk_soc);
        bus.bclk = 1'b1;
        if (popx) begin
            repeat (3) @(negedge clk_soc);
            bus.read_frame = 1'b1;
            @(negedge clk_soc);
            bus.read_frame = 1'b0;
            repeat (HALF - 4) @(negedge clk_soc);
        end else begin
            repeat (HALF) @(negedge clk_soc);
        end
        bus.bclk = 1'b0;
    endtask

    // Bit positions k0..k0+n-1 of a 32-bit slot; MSB sits at position 1.
    task automatic send_slot(input bit lr, input logic [23:0] w, input int k0, input int n,
                             input bit popx);
        logic d;
        for (int k = k0; k < k0 + n; k++) begin
            d = (k >= 1 && k <= 24) ? w[24-k] : 1'b0;
            send_bit(lr, d, popx && (k == 0));
        end
    endtask

    // Preamble right slot, table frames [first, first+n), then a closing left slot.
    task automatic stream(input int first, input int n, input bit pop_on_close);
        send_slot(1'b1, 24'h0, 0, 32, 1'b0);
        for (int i = first; i < first + n; i++) begin
            send_slot(1'b0, tbl[i].l, 0, 32, 1'b0);
            send_slot(1'b1, tbl[i].r, 0, 32, 1'b0);
        end
        send_slot(1'b0, 24'h0, 0, 32, pop_on_close);
        repeat (4) @(negedge clk_soc);
    endtask

    task automatic pop_one();
        bus.read_frame = 1'b1;
        @(negedge clk_soc);
        bus.read_frame = 1'b0;
        @(negedge clk_soc);
    endtask

    task automatic read_check(input int first, input int n, input string tag);
        for (int i = first; i < first + n; i++) begin
            if (tbl[i].kept) begin
                chk({tag, "_valid"}, 48'(bus.frame_valid), 48'd1);
                chk({tag, "_l"}, 48'(bus.frame_out_l), 48'(tbl[i].l));
                chk({tag, "_r"}, 48'(bus.frame_out_r), 48'(tbl[i].r));
                pop_one();
            end
        end
        chk({tag, "_empty"}, 48'(bus.frame_valid), 48'd0);
    endtask

    task automatic resync();
        bus.enable = 1'b0;
        repeat (3) @(negedge clk_soc);
        bus.enable = 1'b1;
        @(negedge clk_soc);
    endtask

    initial begin
        tbl[0]  = '{24'hA5C3F1, 24'h5A3C0F, 1'b1};
        tbl[1]  = '{24'h123456, 24'h654321, 1'b1};
        tbl[2]  = '{24'h800001, 24'h7FFFFE, 1'b1};
        tbl[3]  = '{24'hFFFFFF, 24'h000001, 1'b1};
        tbl[4]  = '{24'hCAFE01, 24'h0BEEF0, 1'b1};
        tbl[5]  = '{24'h111111, 24'h222222, 1'b1};
        tbl[6]  = '{24'h333333, 24'h444444, 1'b1};
        tbl[7]  = '{24'h555555, 24'h666666, 1'b1};
        tbl[8]  = '{24'h777777, 24'h888888, 1'b1};
        tbl[9]  = '{24'h999999, 24'hAAAAAA, 1'b0};
        tbl[10] = '{24'hBBBBBB, 24'hCCCCCC, 1'b0};
        tbl[11] = '{24'hF00001, 24'h0F0002, 1'b0};
        tbl[12] = '{24'hF00003, 24'h0F0004, 1'b1};
        tbl[13] = '{24'hF00005, 24'h0F0006, 1'b1};
        tbl[14] = '{24'hF00007, 24'h0F0008, 1'b1};
        tbl[15] = '{24'hF00009, 24'h0F000A, 1'b1};
        tbl[16] = '{24'hABCDEF, 24'hFEDCBA, 1'b1};
        tbl[17] = '{24'h0C0FFE, 24'hDEAD00, 1'b1};

        reset            = 1'b1;
        bus.enable       = 1'b1;
        bus.bclk         = 1'b0;
        bus.lrclk        = 1'b0;
        bus.sdata        = 1'b0;
        bus.read_frame   = 1'b0;
        bus.overflow_clr = 1'b0;
        repeat (3) @(negedge clk_soc);
        chk("rst_valid", 48'(bus.frame_valid), 48'd0);
        chk("rst_l", 48'(bus.frame_out_l), 48'd0);
        chk("rst_r", 48'(bus.frame_out_r), 48'd0);
        chk("rst_ovf", 48'(bus.overflow), 48'd0);
        chk("rst_serr", 48'(bus.slot_error), 48'd0);
        reset = 1'b0;
        @(negedge clk_soc);

        // Clean stereo frame, pop, then head holds its last value.
        resync();
        stream(0, 1, 1'b0);
        read_check(0, 1, "clean");
        chk("hold_l", 48'(bus.frame_out_l), 48'hA5C3F1);
        chk("clean_serr", 48'(bus.slot_error), 48'd0);

        // Short (20-bit) left slot, then three good frames.
        resync();
        send_slot(1'b1, 24'h0, 0, 32, 1'b0);
        send_slot(1'b0, 24'h7E57E5, 0, 20, 1'b0);
        send_slot(1'b1, 24'h0, 0, 32, 1'b0);
        chk("short_serr", 48'(bus.slot_error), 48'd1);
        chk("short_nopush", 48'(bus.frame_valid), 48'd0);
        send_slot(1'b0, tbl[1].l, 0, 32, 1'b0);
        send_slot(1'b1, tbl[1].r, 0, 32, 1'b0);
        chk("short_wait_fall", 48'(bus.frame_valid), 48'd0);
        send_slot(1'b0, tbl[2].l, 0, 32, 1'b0);
        send_slot(1'b1, tbl[2].r, 0, 32, 1'b0);
        send_slot(1'b0, tbl[3].l, 0, 32, 1'b0);
        send_slot(1'b1, tbl[3].r, 0, 32, 1'b0);
        send_slot(1'b0, 24'h0, 0, 32, 1'b0);
        repeat (4) @(negedge clk_soc);
        read_check(1, 3, "short");

        // Reset mid right slot; resume capture afterwards.
        resync();
        send_slot(1'b1, 24'h0, 0, 32, 1'b0);
        send_slot(1'b0, 24'h13579B, 0, 32, 1'b0);
        send_slot(1'b1, 24'h2468AC, 0, 10, 1'b0);
        reset = 1'b1;
        #1;
        chk("mid_rst_l", 48'(bus.frame_out_l), 48'd0);
        chk("mid_rst_r", 48'(bus.frame_out_r), 48'd0);
        chk("mid_rst_valid", 48'(bus.frame_valid), 48'd0);
        chk("mid_rst_serr", 48'(bus.slot_error), 48'd0);
        repeat (2) @(negedge clk_soc);
        reset = 1'b0;
        send_slot(1'b1, 24'h2468AC, 10, 22, 1'b0);
        send_slot(1'b0, tbl[4].l, 0, 32, 1'b0);
        send_slot(1'b1, tbl[4].r, 0, 32, 1'b0);
        send_slot(1'b0, 24'h0, 0, 32, 1'b0);
        repeat (4) @(negedge clk_soc);
        read_check(4, 1, "after_rst");

        // Six frames into a depth-4 FIFO.
        resync();
        stream(5, 6, 1'b0);
        chk("full_ovf", 48'(bus.overflow), 48'd1);
        read_check(5, 6, "full");
        bus.overflow_clr = 1'b1;
        @(negedge clk_soc);
        bus.overflow_clr = 1'b0;
        @(negedge clk_soc);
        chk("ovf_clr", 48'(bus.overflow), 48'd0);

        // Push and pop on the same cycle while full.
        resync();
        stream(11, 5, 1'b1);
        chk("pp_ovf", 48'(bus.overflow), 48'd0);
        read_check(11, 5, "pushpop");

        // Start mid right slot with enable low; then drop enable mid left slot.
        bus.enable = 1'b0;
        send_slot(1'b1, 24'h0, 0, 12, 1'b0);
        bus.enable = 1'b1;
        send_slot(1'b1, 24'h0, 12, 20, 1'b0);
        chk("mid_start_nopush", 48'(bus.frame_valid), 48'd0);
        send_slot(1'b0, tbl[16].l, 0, 32, 1'b0);
        send_slot(1'b1, tbl[16].r, 0, 32, 1'b0);
        chk("mid_start_pair", 48'(bus.frame_valid), 48'd0);
        send_slot(1'b0, 24'h5EED00, 0, 12, 1'b0);
        bus.enable = 1'b0;
        repeat (4) @(negedge clk_soc);
        bus.enable = 1'b1;
        send_slot(1'b0, 24'h5EED00, 12, 20, 1'b0);
        send_slot(1'b1, 24'h0BAD00, 0, 32, 1'b0);
        send_slot(1'b0, tbl[17].l, 0, 32, 1'b0);
        send_slot(1'b1, tbl[17].r, 0, 32, 1'b0);
        send_slot(1'b0, 24'h0, 0, 32, 1'b0);
        repeat (4) @(negedge clk_soc);
        chk("en_serr", 48'(bus.slot_error), 48'd0);
        read_check(16, 2, "enable");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
